// File: rtl/pattern_repeat_streamer.sv
// Bit-serial pattern repeater: latches a pattern and repeat count on start and streams it MSB-first over valid/ready.
// Optional stream accumulator enabled by defining REPEAT_ACCUM_EN.
module pattern_repeat_streamer #(
    parameter int PAT_W = 8,
    parameter int CNT_W = 8,
    parameter int SZ_W  = $clog2(PAT_W + 1),
    parameter int ACC_W = 512
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [SZ_W-1:0]  pattern_size,
    input  logic [CNT_W-1:0] times_repeat,
    output logic             bit_out,
    output logic             bit_valid,
    input  logic             bit_ready,
    output logic             busy,
    output logic             done
`ifdef REPEAT_ACCUM_EN
    ,
    output logic [ACC_W-1:0] acc_data,
    output logic [15:0]      acc_count
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [SZ_W-1:0] MAX_SIZE = SZ_W'(PAT_W);

    if (ACC_W < 2) begin : g_acc_w_check
        $error("ACC_W must be at least 2");
    end

    state_t           state_q, state_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [SZ_W-1:0]  size_q, size_d;
    logic [SZ_W-1:0]  bit_idx_q, bit_idx_d;
    logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
    logic [SZ_W-1:0]  eff_size;
    logic [PAT_W-1:0] pat_shift;
    logic             accept;
    logic             beat;

    always_comb begin
        eff_size = (pattern_size > MAX_SIZE) ? MAX_SIZE : pattern_size;
    end

    always_comb begin
        state_d   = state_q;
        pat_d     = pat_q;
        size_d    = size_q;
        bit_idx_d = bit_idx_q;
        rep_cnt_d = rep_cnt_q;
        accept    = 1'b0;
        beat      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    pat_d     = pattern;
                    size_d    = eff_size;
                    rep_cnt_d = times_repeat;
                    bit_idx_d = eff_size - SZ_W'(1);
                    if (eff_size == '0 || times_repeat == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                beat = bit_ready;
                if (beat) begin
                    if (bit_idx_q != '0) begin
                        bit_idx_d = bit_idx_q - SZ_W'(1);
                    end else if (rep_cnt_q > CNT_W'(1)) begin
                        // Wrap straight into the next repetition so there is no bubble.
                        bit_idx_d = size_q - SZ_W'(1);
                        rep_cnt_d = rep_cnt_q - CNT_W'(1);
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
        pat_q     <= pat_d;
        size_q    <= size_d;
        bit_idx_q <= bit_idx_d;
        rep_cnt_q <= rep_cnt_d;
    end

    always_comb begin
        pat_shift = pat_q >> bit_idx_q;
        bit_valid = (state_q == S_RUN);
        busy      = (state_q == S_RUN);
        done      = (state_q == S_DONE);
        bit_out   = bit_valid & pat_shift[0];
    end

`ifdef REPEAT_ACCUM_EN
    logic [ACC_W-1:0] acc_data_q, acc_data_d;
    logic [15:0]      acc_count_q, acc_count_d;

    always_comb begin
        acc_data_d  = acc_data_q;
        acc_count_d = acc_count_q;
        if (accept) begin
            acc_data_d  = '0;
            acc_count_d = '0;
        end else if (beat) begin
            acc_data_d = {acc_data_q[ACC_W-2:0], bit_out};
            if (acc_count_q != 16'hFFFF) begin
                acc_count_d = acc_count_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_data_q  <= '0;
            acc_count_q <= '0;
        end else begin
            acc_data_q  <= acc_data_d;
            acc_count_q <= acc_count_d;
        end
    end

    assign acc_data  = acc_data_q;
    assign acc_count = acc_count_q;
`endif

endmodule

// File: tb/tb_pattern_repeat_streamer.sv
// Directed self-checking bench for pattern_repeat_streamer (PAT_W=8, CNT_W=8).
module tb_pattern_repeat_streamer;

    localparam int PAT_W = 8;
    localparam int CNT_W = 8;
    localparam int SZ_W  = 4;
    localparam int ACC_W = 512;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [PAT_W-1:0] pattern;
    logic [SZ_W-1:0]  pattern_size;
    logic [CNT_W-1:0] times_repeat;
    logic             bit_out;
    logic             bit_valid;
    logic             bit_ready;
    logic             busy;
    logic             done;
`ifdef REPEAT_ACCUM_EN
    logic [ACC_W-1:0] acc_data;
    logic [15:0]      acc_count;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pattern_repeat_streamer #(
        .PAT_W(PAT_W),
        .CNT_W(CNT_W),
        .ACC_W(ACC_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .pattern(pattern),
        .pattern_size(pattern_size),
        .times_repeat(times_repeat),
        .bit_out(bit_out),
        .bit_valid(bit_valid),
        .bit_ready(bit_ready),
        .busy(busy),
`ifdef REPEAT_ACCUM_EN
        .acc_data(acc_data),
        .acc_count(acc_count),
`endif
        .done(done)
    );

    // Returns at 1 ns after the accepting edge.
    task automatic do_start(input logic [7:0] pat, input logic [3:0] sz, input logic [7:0] rep);
        @(posedge clk);
        #1;
        pattern      = pat;
        pattern_size = sz;
        times_repeat = rep;
        start        = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        start        = 1'b0;
        bit_ready    = 1'b0;
        pattern      = '0;
        pattern_size = '0;
        times_repeat = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({bit_out, bit_valid, busy, done} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_outputs got %b exp 0000", {bit_out, bit_valid, busy, done});
        end
`ifdef REPEAT_ACCUM_EN
        checks++;
        if (acc_data !== '0 || acc_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_acc got count %0d exp 0", acc_count);
        end
`endif
    endtask

    task automatic test_long();
        int beats = 0, bad = 0, busy_cyc = 0, done_cnt = 0, done_cyc = 0;
        logic exp_bit;
        logic [ACC_W-1:0] exp_acc;
        bit_ready = 1'b1;
        do_start(8'h0C, 4'd4, 8'd75);
        for (int cyc = 1; cyc <= 310; cyc++) begin
            @(negedge clk);
            if (busy) busy_cyc++;
            if (bit_valid && bit_ready) begin
                exp_bit = ((beats % 4) < 2);
                if (bit_out !== exp_bit) bad++;
                beats++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL long_bits got %0d wrong bits exp 0", bad); end
        checks++;
        if (beats != 300) begin errors++; $display("FAIL long_beats got %0d exp 300", beats); end
        checks++;
        if (busy_cyc != 300) begin errors++; $display("FAIL long_busy got %0d exp 300", busy_cyc); end
        checks++;
        if (done_cnt != 1) begin errors++; $display("FAIL long_done_count got %0d exp 1", done_cnt); end
        checks++;
        if (done_cyc != 301) begin errors++; $display("FAIL long_done_cycle got %0d exp 301", done_cyc); end
        exp_acc = '0;
        for (int r = 0; r < 75; r++) exp_acc = {exp_acc[ACC_W-5:0], 4'b1100};
`ifdef REPEAT_ACCUM_EN
        checks++;
        if (acc_data !== exp_acc) begin errors++; $display("FAIL long_acc_data got %0h exp %0h", acc_data[299:0], exp_acc[299:0]); end
        checks++;
        if (acc_count !== 16'd300) begin errors++; $display("FAIL long_acc_count got %0d exp 300", acc_count); end
`endif
    endtask

    task automatic test_stall();
        logic [15:0] rp;
        logic [5:0]  seq;
        int beats = 0, bad = 0, stall_bad = 0, done_cnt = 0;
        logic prev_stall, prev_bit;
        rp = 16'b1011_0010_0110_1001;
        seq = 6'b101101;
        prev_stall = 1'b0;
        prev_bit   = 1'b0;
        bit_ready  = 1'b0;
        do_start(8'hA5, 4'd3, 8'd2);
        for (int cyc = 1; cyc <= 60; cyc++) begin
            bit_ready = rp[cyc % 16];
            @(negedge clk);
            if (prev_stall && (bit_out !== prev_bit || bit_valid !== 1'b1)) stall_bad++;
            if (bit_valid && bit_ready) begin
                if (beats < 6) begin
                    if (bit_out !== seq[5-beats]) bad++;
                end else begin
                    bad++;
                end
                beats++;
            end
            if (done) done_cnt++;
            prev_stall = bit_valid && !bit_ready;
            prev_bit   = bit_out;
            @(posedge clk);
            #1;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL stall_bits got %0d wrong bits exp 0", bad); end
        checks++;
        if (beats != 6) begin errors++; $display("FAIL stall_beats got %0d exp 6", beats); end
        checks++;
        if (stall_bad != 0) begin errors++; $display("FAIL stall_stable got %0d unstable cycles exp 0", stall_bad); end
        checks++;
        if (done_cnt != 1) begin errors++; $display("FAIL stall_done_count got %0d exp 1", done_cnt); end
`ifdef REPEAT_ACCUM_EN
        checks++;
        if (acc_data !== ACC_W'(6'b101101) || acc_count !== 16'd6) begin
            errors++;
            $display("FAIL stall_acc got data %0h count %0d exp 2d count 6", acc_data[15:0], acc_count);
        end
`endif
    endtask

    task automatic test_zero();
        logic [3:0] sz_tab [2];
        logic [7:0] rep_tab [2];
        int busy_seen, extra_done;
        sz_tab[0] = 4'd0; rep_tab[0] = 8'd5;
        sz_tab[1] = 4'd4; rep_tab[1] = 8'd0;
        bit_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            busy_seen  = 0;
            extra_done = 0;
            do_start(8'hFF, sz_tab[i], rep_tab[i]);
            @(negedge clk);
            checks++;
            if (done !== 1'b1 || bit_valid !== 1'b0) begin
                errors++;
                $display("FAIL zero_done_case%0d got done %b valid %b exp 1 0", i, done, bit_valid);
            end
            if (busy) busy_seen++;
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                if (busy || bit_valid) busy_seen++;
                if (done) extra_done++;
            end
            checks++;
            if (busy_seen != 0 || extra_done != 0) begin
                errors++;
                $display("FAIL zero_quiet_case%0d got busy %0d extra_done %0d exp 0 0", i, busy_seen, extra_done);
            end
`ifdef REPEAT_ACCUM_EN
            checks++;
            if (acc_count !== 16'd0) begin errors++; $display("FAIL zero_acc_clear_case%0d got %0d exp 0", i, acc_count); end
`endif
        end
    endtask

    task automatic test_clamp();
        logic [7:0] got;
        int beats = 0, done_cnt = 0;
        got = '0;
        bit_ready = 1'b1;
        do_start(8'hCA, 4'd9, 8'd1);
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(negedge clk);
            if (bit_valid && bit_ready) begin
                got = {got[6:0], bit_out};
                beats++;
            end
            if (done) done_cnt++;
        end
        checks++;
        if (beats != 8) begin errors++; $display("FAIL clamp_beats got %0d exp 8", beats); end
        checks++;
        if (got !== 8'hCA) begin errors++; $display("FAIL clamp_bits got %h exp ca", got); end
        checks++;
        if (done_cnt != 1) begin errors++; $display("FAIL clamp_done_count got %0d exp 1", done_cnt); end
    endtask

    task automatic test_abort();
        int beats = 0, bad = 0, noise = 0, done_cnt = 0;
        logic exp_bit;
        logic [7:0] got;
        bit_ready = 1'b1;
        do_start(8'hF0, 4'd8, 8'd10);
        for (int k = 0; k < 12; k++) begin
            if (k == 3) begin
                start        = 1'b1;
                pattern      = 8'h00;
                pattern_size = 4'd1;
                times_repeat = 8'd1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (bit_valid && bit_ready) begin
                exp_bit = ((beats % 8) < 4);
                if (bit_out !== exp_bit) bad++;
                beats++;
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        checks++;
        if (bad != 0 || beats != 12) begin
            errors++;
            $display("FAIL abort_ignore_start got %0d beats %0d wrong exp 12 0", beats, bad);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({bit_out, bit_valid, busy, done} !== 4'b0000) begin
            errors++;
            $display("FAIL abort_reset_outputs got %b exp 0000", {bit_out, bit_valid, busy, done});
        end
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (done || bit_valid || busy) noise++;
        end
        checks++;
        if (noise != 0) begin errors++; $display("FAIL abort_no_done got %0d active cycles exp 0", noise); end
        got   = '0;
        beats = 0;
        do_start(8'h06, 4'd4, 8'd2);
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(negedge clk);
            if (bit_valid && bit_ready) begin
                got = {got[6:0], bit_out};
                beats++;
            end
            if (done) done_cnt++;
        end
        checks++;
        if (got !== 8'h66 || beats != 8 || done_cnt != 1) begin
            errors++;
            $display("FAIL abort_restart got bits %h beats %0d done %0d exp 66 8 1", got, beats, done_cnt);
        end
    endtask

    task automatic test_max();
        int beats = 0, bad = 0, bubbles = 0, done_cyc = 0, done_cnt = 0;
        logic [7:0] pat;
        logic [7:0] sh;
        pat = 8'hB4;
        bit_ready = 1'b1;
        do_start(pat, 4'd8, 8'd255);
        for (int cyc = 1; cyc <= 2050; cyc++) begin
            @(negedge clk);
            if (cyc <= 2040 && !bit_valid) bubbles++;
            if (bit_valid && bit_ready) begin
                sh = pat >> (7 - (beats % 8));
                if (bit_out !== sh[0]) bad++;
                beats++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
        checks++;
        if (beats != 2040) begin errors++; $display("FAIL max_beats got %0d exp 2040", beats); end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL max_bits got %0d wrong bits exp 0", bad); end
        checks++;
        if (bubbles != 0) begin errors++; $display("FAIL max_bubbles got %0d exp 0", bubbles); end
        checks++;
        if (done_cnt != 1 || done_cyc != 2041) begin
            errors++;
            $display("FAIL max_done got count %0d cycle %0d exp 1 2041", done_cnt, done_cyc);
        end
`ifdef REPEAT_ACCUM_EN
        checks++;
        if (acc_data !== {64{8'hB4}} || acc_count !== 16'd2040) begin
            errors++;
            $display("FAIL max_acc got low %0h count %0d exp b4b4 2040", acc_data[15:0], acc_count);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_long();
        test_stall();
        test_zero();
        test_clamp();
        test_abort();
        test_max();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
